// File: rtl/prbs31_if.sv
// Link between the serial PRBS31 source and the checker. The source side
// drives the serial bit, its qualifier and the error-clear; the checker drives status.
interface prbs31_if #(
  parameter int ERR_W = 16
);
  logic             din_valid;
  logic             din;
  logic             clear_errs;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state;

  modport master (
    output din_valid, din, clear_errs,
    input  locked, err_pulse, err_count, state
  );

  modport slave (
    input  din_valid, din, clear_errs,
    output locked, err_pulse, err_count, state
  );
endinterface

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 (x^31 + x^28 + 1) receive checker: hunts for a
// nonzero seed, verifies predictions, then counts bit errors while locked.
module prbs31_checker #(
  parameter int LOCK_MATCHES = 32,
  parameter int LOSS_WINDOW  = 64,
  parameter int LOSS_ERRS    = 8,
  parameter int ERR_W        = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  prbs31_if.slave  bus
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [4:0] FILL_FULL = 5'd31;
  localparam logic [7:0] MATCH_TGT = 8'(LOCK_MATCHES);
  localparam logic [7:0] WIN_LAST  = 8'(LOSS_WINDOW - 1);
  localparam logic [8:0] ERR_TRIP  = 9'(LOSS_ERRS);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [30:0]      sr_p0;
  logic [1:0]       state_p0;
  logic [4:0]       fill_p0;
  logic [7:0]       match_p0;
  logic [7:0]       win_p0;
  logic [8:0]       werr_p0;
  logic [ERR_W-1:0] err_count_p0;
  logic             err_pulse_p0;
  logic             locked_p0;

  logic [30:0]      sr_nx;
  logic [30:0]      sr_shift;
  logic [1:0]       state_nx;
  logic [4:0]       fill_nx;
  logic [4:0]       fill_inc;
  logic [7:0]       match_nx;
  logic [7:0]       match_inc;
  logic [7:0]       win_nx;
  logic [8:0]       werr_nx;
  logic [8:0]       werr_inc;
  logic [ERR_W-1:0] err_count_nx;
  logic             err_pulse_nx;
  logic             pred;
  logic             mis;

  always_comb begin
    // Received bits, never predictions, enter the register so the checker
    // re-seeds itself from the line after any loss of lock.
    pred      = sr_p0[27] ^ sr_p0[30];
    mis       = bus.din != pred;
    sr_shift  = {sr_p0[29:0], bus.din};
    fill_inc  = (fill_p0 == FILL_FULL) ? FILL_FULL : fill_p0 + 5'd1;
    match_inc = match_p0 + 8'd1;
    werr_inc  = werr_p0 + {8'd0, mis};

    sr_nx        = sr_p0;
    state_nx     = state_p0;
    fill_nx      = fill_p0;
    match_nx     = match_p0;
    win_nx       = win_p0;
    werr_nx      = werr_p0;
    err_count_nx = err_count_p0;
    err_pulse_nx = 1'b0;

    if (bus.din_valid) begin
      sr_nx = sr_shift;
      case (state_p0)
        ST_HUNT: begin
          fill_nx = fill_inc;
          if (fill_inc == FILL_FULL && sr_shift != '0) begin
            state_nx = ST_VERIFY;
            match_nx = 8'd0;
          end
        end
        ST_VERIFY: begin
          if (mis) begin
            state_nx = ST_HUNT;
            fill_nx  = 5'd0;
          end else begin
            match_nx = match_inc;
            if (match_inc == MATCH_TGT) begin
              state_nx = ST_LOCKED;
              win_nx   = 8'd0;
              werr_nx  = 9'd0;
            end
          end
        end
        ST_LOCKED: begin
          err_pulse_nx = mis;
          if (mis) err_count_nx = sat_inc(err_count_p0);
          // The last bit of a window still belongs to it, so the trip test
          // uses the pre-wrap count.
          if (werr_inc == ERR_TRIP) begin
            state_nx = ST_HUNT;
            fill_nx  = 5'd0;
          end else if (win_p0 == WIN_LAST) begin
            win_nx  = 8'd0;
            werr_nx = 9'd0;
          end else begin
            win_nx  = win_p0 + 8'd1;
            werr_nx = werr_inc;
          end
        end
        default: state_nx = ST_HUNT;
      endcase
    end

    if (bus.clear_errs) err_count_nx = '0;
  end

  // Stage p0: state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_p0        <= '0;
      state_p0     <= ST_HUNT;
      fill_p0      <= '0;
      match_p0     <= '0;
      win_p0       <= '0;
      werr_p0      <= '0;
      err_count_p0 <= '0;
      err_pulse_p0 <= 1'b0;
      locked_p0    <= 1'b0;
    end else begin
      sr_p0        <= sr_nx;
      state_p0     <= state_nx;
      fill_p0      <= fill_nx;
      match_p0     <= match_nx;
      win_p0       <= win_nx;
      werr_p0      <= werr_nx;
      err_count_p0 <= err_count_nx;
      err_pulse_p0 <= err_pulse_nx;
      locked_p0    <= (state_nx == ST_LOCKED);
    end
  end

  assign bus.state     = state_p0;
  assign bus.locked    = locked_p0;
  assign bus.err_pulse = err_pulse_p0;
  assign bus.err_count = err_count_p0;

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: cycle scoreboard against a bit-history model,
// a table for the single-flip error pattern, and directed lock/loss/reset sequences.
module tb_prbs31_checker;
  localparam int ERR_W        = 16;
  localparam int LOCK_MATCHES = 32;
  localparam int LOSS_WINDOW  = 64;
  localparam int LOSS_ERRS    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  prbs31_if #(.ERR_W(ERR_W)) bus ();

  prbs31_checker #(
    .LOCK_MATCHES(LOCK_MATCHES),
    .LOSS_WINDOW (LOSS_WINDOW),
    .LOSS_ERRS   (LOSS_ERRS),
    .ERR_W       (ERR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]       st;
    logic             lk;
    logic             pls;
    logic [ERR_W-1:0] cnt;
  } exp_t;

  typedef struct {
    bit flip;
    bit exp_pulse;
    bit exp_locked;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];
  vec_t vec[40];

  bit rx[$];
  int m_state, m_fill, m_match, m_win, m_werr, m_cnt;
  bit m_pulse;
  logic [30:0] g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic gen_next(output logic o);
    o = g[30];
    g = {g[29:0], g[27] ^ g[30]};
  endtask

  task automatic model_reset();
    rx.delete();
    m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_cnt = 0;
    m_pulse = 1'b0;
    g = 31'd1;
  endtask

  // Reference built on the received-bit history rather than a shift register
  task automatic model_step(input bit v, input bit d, input bit clr);
    bit pred, mis, nz;
    int n;
    m_pulse = 1'b0;
    if (v) begin
      n    = rx.size();
      pred = ((n >= 28) ? rx[n-28] : 1'b0) ^ ((n >= 31) ? rx[n-31] : 1'b0);
      mis  = (d != pred);
      rx.push_back(d);
      nz = 1'b0;
      for (int k = 0; k < 31 && k <= n; k++) if (rx[n-k]) nz = 1'b1;
      case (m_state)
        0: begin
          if (m_fill < 31) m_fill++;
          if (m_fill == 31 && nz) begin m_state = 1; m_match = 0; end
        end
        1: begin
          if (mis) begin m_state = 0; m_fill = 0; end
          else begin
            m_match++;
            if (m_match == LOCK_MATCHES) begin m_state = 2; m_win = 0; m_werr = 0; end
          end
        end
        default: begin
          if (mis) begin
            m_pulse = 1'b1;
            m_werr++;
            if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
          end
          m_win++;
          if (m_werr >= LOSS_ERRS) begin m_state = 0; m_fill = 0; end
          else if (m_win == LOSS_WINDOW) begin m_win = 0; m_werr = 0; end
        end
      endcase
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_state",  32'(bus.state),     32'(e.st));
      chk("sb_locked", 32'(bus.locked),    32'(e.lk));
      chk("sb_pulse",  32'(bus.err_pulse), 32'(e.pls));
      chk("sb_count",  32'(bus.err_count), 32'(e.cnt));
    end
  endtask

  task automatic cycle(input bit v, input bit d, input bit clr);
    exp_t e;
    @(negedge clk);
    sb_check();
    bus.din_valid  = v;
    bus.din        = d;
    bus.clear_errs = clr;
    model_step(v, d, clr);
    e.st  = 2'(m_state);
    e.lk  = (m_state == 2);
    e.pls = m_pulse;
    e.cnt = ERR_W'(m_cnt);
    sb_q.push_back(e);
  endtask

  task automatic send(input bit flip, input bit clr);
    logic b;
    gen_next(b);
    cycle(1'b1, b ^ flip, clr);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sb_check();
    #2;
    rst_n          = 1'b0;
    bus.din_valid  = 1'b0;
    bus.din        = 1'b0;
    bus.clear_errs = 1'b0;
    #1;
    chk("rst_state",  32'(bus.state),     32'd0);
    chk("rst_locked", 32'(bus.locked),    32'd0);
    chk("rst_pulse",  32'(bus.err_pulse), 32'd0);
    chk("rst_count",  32'(bus.err_count), 32'd0);
    sb_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Clean stream from reset: VERIFY after bit 31, LOCKED after bit 63
  task automatic lock_run();
    for (int i = 1; i <= 63; i++) begin
      send(1'b0, 1'b0);
      if (i == 30) begin after_edge(); chk("hunt_at_30",   32'(bus.state),  32'd0); end
      if (i == 31) begin after_edge(); chk("verify_at_31", 32'(bus.state),  32'd1); end
      if (i == 62) begin after_edge(); chk("unlock_at_62", 32'(bus.locked), 32'd0); end
      if (i == 63) begin after_edge(); chk("lock_at_63",   32'(bus.locked), 32'd1); end
    end
  endtask

  initial begin
    int nvalid, iters;
    for (int i = 0; i < 40; i++) begin
      vec[i].flip       = (i == 0);
      vec[i].exp_pulse  = (i == 0 || i == 28 || i == 31);
      vec[i].exp_locked = 1'b1;
    end
    bus.din_valid  = 1'b0;
    bus.din        = 1'b0;
    bus.clear_errs = 1'b0;
    model_reset();

    // Clean lock and long error-free run
    do_reset();
    lock_run();
    for (int i = 64; i <= 10000; i++) send(1'b0, 1'b0);
    after_edge();
    chk("clean_10k_count", 32'(bus.err_count), 32'd0);

    // Single flipped bit: pulses at +0, +28, +31
    for (int i = 0; i < 40; i++) begin
      send(vec[i].flip, 1'b0);
      after_edge();
      chk($sformatf("flip_pulse_%0d", i),  32'(bus.err_pulse), 32'(vec[i].exp_pulse));
      chk($sformatf("flip_locked_%0d", i), 32'(bus.locked),    32'(vec[i].exp_locked));
    end
    chk("flip_count", 32'(bus.err_count), 32'd3);

    // Eight flips inside one window force loss of lock, then relock
    do_reset();
    lock_run();
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
    for (int j = 0; j <= 21; j++) begin
      send(j % 3 == 0, 1'b0);
      if (j == 18) begin after_edge(); chk("loss_hold_7", 32'(bus.locked), 32'd1); end
    end
    after_edge();
    chk("loss_locked", 32'(bus.locked),    32'd0);
    chk("loss_state",  32'(bus.state),     32'd0);
    chk("loss_count",  32'(bus.err_count), 32'd8);
    for (int i = 1; i <= 63; i++) begin
      send(1'b0, 1'b0);
      if (i == 62) begin after_edge(); chk("relock_62", 32'(bus.locked), 32'd0); end
    end
    after_edge();
    chk("relock_63", 32'(bus.locked), 32'd1);
    chk("relock_count_kept", 32'(bus.err_count), 32'd8);

    // All-zero line never leaves HUNT
    do_reset();
    for (int i = 0; i < 500; i++) cycle(1'b1, 1'b0, 1'b0);
    after_edge();
    chk("zeros_state",  32'(bus.state),     32'd0);
    chk("zeros_locked", 32'(bus.locked),    32'd0);
    chk("zeros_count",  32'(bus.err_count), 32'd0);

    // Random valid gaps: lock after exactly 63 valid bits
    do_reset();
    nvalid = 0;
    iters  = 0;
    while (nvalid < 63 && iters < 2000) begin
      iters++;
      if ($urandom_range(0, 1) == 1) begin
        send(1'b0, 1'b0);
        nvalid++;
        if (nvalid == 62) begin after_edge(); chk("gap_unlock_62", 32'(bus.locked), 32'd0); end
      end else begin
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    chk("gap_budget", 32'(nvalid), 32'd63);
    after_edge();
    chk("gap_lock_63", 32'(bus.locked), 32'd1);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) send(1'b0, 1'b0);
      else cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    after_edge();
    chk("gap_clean_count", 32'(bus.err_count), 32'd0);
    send(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) send(1'b0, 1'b0);
    after_edge();
    chk("pre_clear_count", 32'(bus.err_count), 32'd3);
    send(1'b1, 1'b1);
    after_edge();
    chk("clear_wins_count", 32'(bus.err_count), 32'd0);
    chk("clear_wins_pulse", 32'(bus.err_pulse), 32'd1);

    // Asynchronous reset while locked with five counted errors
    do_reset();
    lock_run();
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
    for (int j = 0; j <= 12; j++) send(j % 3 == 0, 1'b0);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
    after_edge();
    chk("pre_rst_count",  32'(bus.err_count), 32'd5);
    chk("pre_rst_locked", 32'(bus.locked),    32'd1);
    do_reset();
    lock_run();
    after_edge();
    chk("post_rst_count", 32'(bus.err_count), 32'd0);

    @(negedge clk);
    sb_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
